conv_row_sequencer: RTL

- Sequences one full 3x3 convolution pass over the input image BRAM.
- Issues input-row read addresses to the 130-pixel-row input BRAM and selects the matching 24-bit kernel row for CONV128.
- Tracks BRAM and CONV128 latency with tag shift registers, then issues write address and write enable to the 128-pixel-row output BRAM.
- Replaces the split control_input/output_control pair with one pipelined scheduler: one input row per clock, no bubbles between output rows.

---
 rtl/conv_row_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_row_sequencer.sv
// Pipelined 3x3 convolution row scheduler: issues input-row reads, aligns kernel rows to BRAM data,
// and issues output-row writes. Optional build macro CONV_SEQ_PAUSE_EN adds a row-boundary issue stall input (pause).
module conv_row_sequencer #(
  parameter int OUT_ROWS = 128,
  parameter int IN_AW    = 8,
  parameter int OUT_AW   = 7,
  parameter int RAM_LAT  = 1,
  parameter int CONV_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              conv_run,
`ifdef CONV_SEQ_PAUSE_EN
  input  logic              pause,
`endif
  input  logic [71:0]       kernel,
  output logic              in_en,
  output logic [IN_AW-1:0]  in_addr,
  output logic [23:0]       weight,
  output logic              acc_valid,
  output logic              acc_clear,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  // conv_run is a level request accepted only in IDLE; nothing downstream can
  // stall, so every strobe (in_en, acc_valid, out_we) is a one-cycle valid with no ready.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [71:0]         kernel_q, kernel_d;
  logic [OUT_AW-1:0]   iss_r_q, iss_r_d;
  logic [1:0]          iss_k_q, iss_k_d;
  logic                in_en_q, in_en_d;
  logic [IN_AW-1:0]    in_addr_q, in_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [23:0]         weight_q, weight_d;
  logic                acc_clear_q, acc_clear_d;

  logic [OUT_AW-1:0]   nxt_r;
  logic [1:0]          nxt_k;
  logic                last_issue;
  logic                pause_w;
  logic                pipe_pend_d;
  logic                wr_pend_d;

  logic [RAM_LAT-1:0]  rd_v_q, rd_v_d;
  logic [1:0]          rd_k_q [RAM_LAT];
  logic [1:0]          rd_k_d [RAM_LAT];
  logic [OUT_AW-1:0]   rd_r_q [RAM_LAT];
  logic [OUT_AW-1:0]   rd_r_d [RAM_LAT];

  logic                wr_in_v;
  logic [OUT_AW-1:0]   wr_in_r;

`ifdef CONV_SEQ_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // iss_r/iss_k hold the last issued tag, or the held tag while a pause keeps in_en low.
  always_comb begin
    nxt_r = iss_r_q;
    nxt_k = iss_k_q;
    if (in_en_q) begin
      if (iss_k_q == 2'd2) begin
        nxt_k = 2'd0;
        nxt_r = iss_r_q + OUT_AW'(1);
      end else begin
        nxt_k = iss_k_q + 2'd1;
      end
    end
    last_issue = in_en_q && (iss_k_q == 2'd2) && (iss_r_q == OUT_AW'(OUT_ROWS - 1));
  end

  always_comb begin
    state_d   = state_q;
    kernel_d  = kernel_q;
    iss_r_d   = iss_r_q;
    iss_k_d   = iss_k_q;
    in_en_d   = 1'b0;
    in_addr_d = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (conv_run) begin
          state_d  = ST_ISSUE;
          kernel_d = kernel;
          iss_r_d  = '0;
          iss_k_d  = '0;
          in_en_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (last_issue) begin
          state_d = ST_DRAIN;
        end else if ((nxt_k == 2'd0) && pause_w) begin
          iss_r_d = nxt_r;
          iss_k_d = nxt_k;
        end else begin
          iss_r_d   = nxt_r;
          iss_k_d   = nxt_k;
          in_en_d   = 1'b1;
          in_addr_d = IN_AW'(nxt_r) + IN_AW'(nxt_k);
        end
      end
      ST_DRAIN: begin
        if (!pipe_pend_d) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      kernel_q  <= '0;
      iss_r_q   <= '0;
      iss_k_q   <= '0;
      in_en_q   <= 1'b0;
      in_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kernel_q  <= kernel_d;
      iss_r_q   <= iss_r_d;
      iss_k_q   <= iss_k_d;
      in_en_q   <= in_en_d;
      in_addr_q <= in_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Read tag pipeline: the last stage lines up with BRAM data.
  always_comb begin
    rd_v_d    = (rd_v_q << 1) | RAM_LAT'(in_en_q);
    rd_k_d[0] = in_en_q ? iss_k_q : 2'd0;
    rd_r_d[0] = in_en_q ? iss_r_q : '0;
    for (int i = 1; i < RAM_LAT; i++) begin
      rd_k_d[i] = rd_k_q[i-1];
      rd_r_d[i] = rd_r_q[i-1];
    end
    weight_d    = '0;
    acc_clear_d = 1'b0;
    if (rd_v_d[RAM_LAT-1]) begin
      acc_clear_d = (rd_k_d[RAM_LAT-1] == 2'd0);
      case (rd_k_d[RAM_LAT-1])
        2'd0:    weight_d = kernel_q[23:0];
        2'd1:    weight_d = kernel_q[47:24];
        default: weight_d = kernel_q[71:48];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_v_q      <= '0;
      weight_q    <= '0;
      acc_clear_q <= 1'b0;
      for (int i = 0; i < RAM_LAT; i++) begin
        rd_k_q[i] <= '0;
        rd_r_q[i] <= '0;
      end
    end else begin
      rd_v_q      <= rd_v_d;
      weight_q    <= weight_d;
      acc_clear_q <= acc_clear_d;
      for (int i = 0; i < RAM_LAT; i++) begin
        rd_k_q[i] <= rd_k_d[i];
        rd_r_q[i] <= rd_r_d[i];
      end
    end
  end

  // Kernel row 2 closes an output row; its tag rides the CONV128 latency to the write port.
  assign wr_in_v = rd_v_q[RAM_LAT-1] && (rd_k_q[RAM_LAT-1] == 2'd2);
  assign wr_in_r = wr_in_v ? rd_r_q[RAM_LAT-1] : '0;

  generate
    if (CONV_LAT == 0) begin : g_wr_bypass
      assign out_we    = wr_in_v;
      assign out_addr  = wr_in_r;
      assign wr_pend_d = 1'b0;
    end else begin : g_wr_pipe
      logic [CONV_LAT-1:0] wr_v_q, wr_v_d;
      logic [OUT_AW-1:0]   wr_r_q [CONV_LAT];
      logic [OUT_AW-1:0]   wr_r_d [CONV_LAT];

      always_comb begin
        wr_v_d    = (wr_v_q << 1) | CONV_LAT'(wr_in_v);
        wr_r_d[0] = wr_in_r;
        for (int i = 1; i < CONV_LAT; i++) begin
          wr_r_d[i] = wr_r_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          wr_v_q <= '0;
          for (int i = 0; i < CONV_LAT; i++) begin
            wr_r_q[i] <= '0;
          end
        end else begin
          wr_v_q <= wr_v_d;
          for (int i = 0; i < CONV_LAT; i++) begin
            wr_r_q[i] <= wr_r_d[i];
          end
        end
      end

      assign out_we    = wr_v_q[CONV_LAT-1];
      assign out_addr  = wr_r_q[CONV_LAT-1];
      assign wr_pend_d = |wr_v_d;
    end
  endgenerate

  // DRAIN ends on the edge where the final write leaves, so done lands one cycle after it.
  assign pipe_pend_d = (|rd_v_d) | wr_pend_d;

  assign in_en     = in_en_q;
  assign in_addr   = in_addr_q;
  assign weight    = weight_q;
  assign acc_valid = rd_v_q[RAM_LAT-1];
  assign acc_clear = acc_clear_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
